debug_trace_serializer: RTL and testbench
=========================================

Name: debug_trace_serializer

Overview:
- Sits between the dual-lane commit debug buses and the single-port golden-trace interface (debug_wb_*).
- Accepts up to two committed debug records per cycle and buffers them in program order, lane 1 before lane 2.
- Emits at most one record per cycle.
- Raises a stall request to commit before its buffer can overflow, and counts emitted records.

Parameters:
- DEPTH, 8, buffer entries; power of two, at least 4.
- FILTER_NOWB, 1, when 1, drop records with wstrb==0 or dest==0 at enqueue.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- debug_bus1  in  debug_bus_t  commit lane 1 record (valid, pc, wstrb, dest, phy_dest, wdata, br_op, predict_sucess)
- debug_bus2  in  debug_bus_t  commit lane 2 record; younger than lane 1
- trace_stall  out  1  commit must not present new records while high
- debug_wb_valid  out  1  trace output holds a record this cycle
- debug_wb_pc  out  32  record pc
- debug_wb_rf_wen  out  4  record wstrb
- debug_wb_rf_wnum  out  5  record dest
- debug_wb_rf_wdata  out  32  record wdata
- overflow_err  out  1  sticky: a record was dropped for lack of space
- trace_count  out  32  number of records emitted, wraps

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high. On reset, all outputs, head, tail and count go to 0.
- Lane qualification:
  - A lane is a push candidate when valid=1 and, if FILTER_NOWB=1, wstrb!=0 and dest!=0.
  - If only lane 2 qualifies, it is enqueued alone.
- Order: lane 1 is written at tail, lane 2 at tail+1 (or at tail if lane 1 is not a candidate).
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Capacity:
  - free = DEPTH - count, where count is the registered value before this edge. A pop at the same edge does not create space for that cycle's pushes.
  - If candidates exceed free, lane 2 is dropped first, then lane 1.
  - A dropped record sets overflow_err; it clears only on reset.
- Stall: trace_stall = (free < 2), combinational from the registered count.
- Pop:
  - At every edge where count>0 (pre-edge value), the head record is loaded into the debug_wb_* registers, debug_wb_valid is set to 1, head advances, and trace_count increments.
  - If count==0, debug_wb_valid is cleared to 0 and the other debug_wb_* outputs hold their values.
- Latency: a record sampled at edge k into an empty buffer appears on the outputs after edge k+1.
- Throughput: one record per cycle.
- Simultaneous push and pop: count_next = count + pushes - pop, with pushes ∈ {0,1,2} and pop ∈ {0,1}.
- No flush input: committed records are architectural and always drain.
- Reset mid-drain discards buffered records.

Decomposition:
- debug_bus_t already lives in cpu.svh.
- Add to the shared package:
  - trace_rec_t {pc[31:0], wstrb[3:0], dest[4:0], wdata[31:0]}
  - constant TRACE_DEPTH = 8
- One natural sub-module: dual_push_fifo, a 2-write/1-read circular buffer of trace_rec_t with count and free outputs.
- The top level holds filtering, drop/overflow logic, output registers and trace_count.

Test Plan:
- Reset asserted mid-stream with 3 records buffered -> all outputs 0 immediately; after release, debug_wb_valid stays 0 with no input.
- Single lane 1 record {pc=0xBFC00000, wstrb=0xF, dest=2, wdata=0x1234}, buffer empty -> after edge k+1: debug_wb_valid=1 with these values, trace_count=1; next cycle debug_wb_valid=0.
- Dual push every cycle for 4 cycles, pcs 0x100/0x104, 0x108/0x10C, ... -> outputs appear strictly in pc order, one per cycle.
  - trace_stall rises when count reaches 7.
  - overflow_err stays 0 if the bench honours stall.
- Lane 1 wstrb=0 (store) plus lane 2 dest=0, FILTER_NOWB=1 -> nothing enqueued and trace_count unchanged.
  - Same stimulus with FILTER_NOWB=0 -> both records emitted.
- Fill to count=7, then force a dual push ignoring stall -> lane 1 accepted, lane 2 dropped, overflow_err=1 permanently.
- Wrap-around: push 20 alternating single/dual records with drain running -> pointers wrap, order preserved, trace_count equals records pushed.

Source files
------------

// File: rtl/debug_trace_serializer_pkg.sv
// Shared types for the commit debug path: the per-lane commit record and the
// reduced record kept in the golden-trace buffer.
package debug_trace_serializer_pkg;

  localparam int TRACE_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  wstrb;
    logic [4:0]  dest;
    logic [6:0]  phy_dest;
    logic [31:0] wdata;
    logic        br_op;
    logic        predict_sucess;
  } debug_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wstrb;
    logic [4:0]  dest;
    logic [31:0] wdata;
  } trace_rec_t;

  function automatic trace_rec_t to_trace_rec(input debug_bus_t b);
    trace_rec_t r;
    r.pc    = b.pc;
    r.wstrb = b.wstrb;
    r.dest  = b.dest;
    r.wdata = b.wdata;
    return r;
  endfunction

endpackage

// File: rtl/debug_trace_serializer_fifo.sv
// Two-write/one-read circular buffer of trace records; port 1 writes only alongside
// port 0 and lands one slot after it. Caller guarantees writes never exceed free.
module dual_push_fifo
  import debug_trace_serializer_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr0_en,
  input  trace_rec_t               wr0_dat,
  input  logic                     wr1_en,
  input  trace_rec_t               wr1_dat,
  input  logic                     rd_en,
  output trace_rec_t               rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t      mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW-1:0]   tail_p1;
  logic [1:0]      n_push;

  assign tail_p1 = tail + 1'b1;
  assign n_push  = {1'b0, wr0_en} + {1'b0, wr1_en};
  assign rd_dat  = mem[head];
  assign free    = (AW+1)'(DEPTH) - count;

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[tail] <= wr0_dat;
    if (wr1_en) mem[tail_p1] <= wr1_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + AW'(n_push);
      if (rd_en) head <= head + 1'b1;
      count <= count + (AW+1)'(n_push) - (AW+1)'(rd_en);
    end
  end

endmodule

// File: rtl/debug_trace_serializer.sv
// Merges two commit debug lanes into the single golden-trace port in program order,
// one record per cycle, with stall-ahead, sticky drop flag and an emitted-record count.
module debug_trace_serializer
  import debug_trace_serializer_pkg::*;
#(
  parameter int DEPTH       = TRACE_DEPTH,
  parameter bit FILTER_NOWB = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  debug_bus_t  debug_bus1,
  input  debug_bus_t  debug_bus2,
  output logic        trace_stall,
  output logic        debug_wb_valid,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic        overflow_err,
  output logic [31:0] trace_count
);

  localparam int AW = $clog2(DEPTH);

  logic          cand1, cand2;
  logic          acc1, acc2, drop;
  logic          pop;
  trace_rec_t    head_rec;
  logic [AW:0]   count;
  logic [AW:0]   free;
  logic          unused_bus_bits;

  function automatic logic qualifies(input debug_bus_t b);
    if (FILTER_NOWB) return b.valid && (b.wstrb != 4'd0) && (b.dest != 5'd0);
    return b.valid;
  endfunction

  assign cand1 = qualifies(debug_bus1);
  assign cand2 = qualifies(debug_bus2);

  // Space is judged on the pre-edge count; with one slot left lane 2 yields to lane 1.
  always_comb begin
    acc1 = 1'b0;
    acc2 = 1'b0;
    if (free >= (AW+1)'(2)) begin
      acc1 = cand1;
      acc2 = cand2;
    end else if (free == (AW+1)'(1)) begin
      acc1 = cand1;
      acc2 = cand2 && !cand1;
    end
    drop = (cand1 && !acc1) || (cand2 && !acc2);
  end

  assign pop         = (count != '0);
  assign trace_stall = (free < (AW+1)'(2));

  dual_push_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr0_en  (acc1 || acc2),
    .wr0_dat (acc1 ? to_trace_rec(debug_bus1) : to_trace_rec(debug_bus2)),
    .wr1_en  (acc1 && acc2),
    .wr1_dat (to_trace_rec(debug_bus2)),
    .rd_en   (pop),
    .rd_dat  (head_rec),
    .count   (count),
    .free    (free)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debug_wb_valid    <= 1'b0;
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
      overflow_err      <= 1'b0;
      trace_count       <= '0;
    end else begin
      debug_wb_valid <= pop;
      if (pop) begin
        debug_wb_pc       <= head_rec.pc;
        debug_wb_rf_wen   <= head_rec.wstrb;
        debug_wb_rf_wnum  <= head_rec.dest;
        debug_wb_rf_wdata <= head_rec.wdata;
        trace_count       <= trace_count + 32'd1;
      end
      if (drop) overflow_err <= 1'b1;
    end
  end

  assign unused_bus_bits = ^{debug_bus1.phy_dest, debug_bus1.br_op, debug_bus1.predict_sucess,
                             debug_bus2.phy_dest, debug_bus2.br_op, debug_bus2.predict_sucess};

endmodule

// File: tb/tb_debug_trace_serializer.sv
// Directed bench for debug_trace_serializer with an in-order scoreboard of accepted records.
module tb_debug_trace_serializer;
  import debug_trace_serializer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  debug_bus_t bus1, bus2, nf1, nf2, idle;

  logic        stall, wb_valid, ovf;
  logic [31:0] wb_pc, wb_wdata, tcount;
  logic [3:0]  wb_wen;
  logic [4:0]  wb_wnum;

  logic        nf_stall, nf_valid, nf_ovf;
  logic [31:0] nf_pc, nf_wdata, nf_tcount;
  logic [3:0]  nf_wen;
  logic [4:0]  nf_wnum;

  always #5 clk = ~clk;

  debug_trace_serializer #(.DEPTH(8), .FILTER_NOWB(1'b1)) dut (
    .clk(clk), .reset(reset), .debug_bus1(bus1), .debug_bus2(bus2),
    .trace_stall(stall), .debug_wb_valid(wb_valid), .debug_wb_pc(wb_pc),
    .debug_wb_rf_wen(wb_wen), .debug_wb_rf_wnum(wb_wnum), .debug_wb_rf_wdata(wb_wdata),
    .overflow_err(ovf), .trace_count(tcount)
  );

  debug_trace_serializer #(.DEPTH(8), .FILTER_NOWB(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .debug_bus1(nf1), .debug_bus2(nf2),
    .trace_stall(nf_stall), .debug_wb_valid(nf_valid), .debug_wb_pc(nf_pc),
    .debug_wb_rf_wen(nf_wen), .debug_wb_rf_wnum(nf_wnum), .debug_wb_rf_wdata(nf_wdata),
    .overflow_err(nf_ovf), .trace_count(nf_tcount)
  );

  int passed = 0;
  int total  = 0;

  trace_rec_t  expq[$];
  int          mcount = 0;
  logic [31:0] mtc = 0;
  logic        movf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic debug_bus_t mk(input logic [31:0] pc);
    debug_bus_t b;
    b = '0;
    b.valid = 1'b1;
    b.pc    = pc;
    b.wstrb = 4'hF;
    b.dest  = 5'(pc[6:2]) | 5'd1;
    b.wdata = pc ^ 32'h5A5A_0000;
    return b;
  endfunction

  function automatic bit cand(input debug_bus_t b);
    return b.valid && (b.wstrb != 4'd0) && (b.dest != 5'd0);
  endfunction

  // Drive one cycle of input, predict the edge, then check the filtered instance.
  task automatic tick(input debug_bus_t b1, input debug_bus_t b2);
    bit c1, c2, a1, a2, pop;
    int fr;
    trace_rec_t e;
    e = '0;
    bus1 = b1;
    bus2 = b2;
    c1 = cand(b1);
    c2 = cand(b2);
    fr = 8 - mcount;
    a1 = c1 && (fr >= 1);
    a2 = c2 && ((fr >= 2) || (fr == 1 && !c1));
    if ((c1 && !a1) || (c2 && !a2)) movf = 1'b1;
    pop = (mcount > 0);
    if (pop) e = expq.pop_front();
    if (a1) expq.push_back(to_trace_rec(b1));
    if (a2) expq.push_back(to_trace_rec(b2));
    mcount = mcount + int'(a1) + int'(a2) - int'(pop);
    if (pop) mtc++;
    @(posedge clk);
    #1;
    chk("wb_valid", wb_valid, pop);
    if (pop) begin
      chk("wb_pc", wb_pc, e.pc);
      chk("wb_wen", wb_wen, e.wstrb);
      chk("wb_wnum", wb_wnum, e.dest);
      chk("wb_wdata", wb_wdata, e.wdata);
    end
    chk("trace_count", tcount, mtc);
    chk("trace_stall", stall, (8 - mcount) < 2);
    chk("overflow_err", ovf, movf);
  endtask

  initial begin
    debug_bus_t f1, f2, one;
    int sent;
    logic [31:0] base;
    bit seen;

    idle = '0;
    bus1 = '0; bus2 = '0; nf1 = '0; nf2 = '0;

    // Power-on reset
    #2 reset = 1'b1;
    #2;
    chk("rst_valid", wb_valid, 0);
    chk("rst_pc", wb_pc, 0);
    chk("rst_count", tcount, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Single lane-1 record into an empty buffer
    one = '0;
    one.valid = 1'b1; one.pc = 32'hBFC0_0000; one.wstrb = 4'hF; one.dest = 5'd2; one.wdata = 32'h1234;
    tick(one, idle);
    chk("single_not_yet", wb_valid, 0);
    tick(idle, idle);
    chk("single_valid", wb_valid, 1);
    chk("single_pc", wb_pc, 32'hBFC0_0000);
    chk("single_wen", wb_wen, 32'hF);
    chk("single_wnum", wb_wnum, 32'd2);
    chk("single_wdata", wb_wdata, 32'h1234);
    chk("single_count", tcount, 32'd1);
    tick(idle, idle);
    chk("single_cleared", wb_valid, 0);
    chk("single_pc_hold", wb_pc, 32'hBFC0_0000);

    // Dual pushes honouring stall: count climbs 2,3,4,5,6,7 then stall
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(mk(32'h100 + 32'(8*i)), mk(32'h104 + 32'(8*i)));
      seen = stall;
    end
    chk("stall_reached", stall, 1);
    chk("no_ovf_when_honoured", ovf, 0);

    // Forced dual push with one slot free: lane 1 kept, lane 2 dropped
    tick(mk(32'h180), mk(32'h184));
    chk("forced_ovf", ovf, 1);
    repeat (10) tick(idle, idle);
    chk("ovf_sticky", ovf, 1);

    // Filtered records: store on lane 1, dest=0 on lane 2
    f1 = mk(32'h200); f1.wstrb = 4'h0;
    f2 = mk(32'h204); f2.dest  = 5'd0;
    base = mtc;
    nf1 = f1; nf2 = f2;
    tick(f1, f2);
    nf1 = idle; nf2 = idle;
    tick(idle, idle);
    chk("nf_valid0", nf_valid, 1);
    chk("nf_pc0", nf_pc, 32'h200);
    chk("nf_wen0", nf_wen, 0);
    tick(idle, idle);
    chk("nf_pc1", nf_pc, 32'h204);
    chk("nf_wnum1", nf_wnum, 0);
    chk("nf_count", nf_tcount, 2);
    chk("nf_ovf", nf_ovf, 0);
    chk("nf_stall", nf_stall, 0);
    tick(idle, idle);
    chk("filter_count_unchanged", tcount, base);
    chk("filter_valid", wb_valid, 0);

    // Wrap-around: 20 records alternating single (either lane) and dual, drain running
    base = mtc;
    sent = 0;
    for (int i = 0; i < 60 && sent < 20; i++) begin
      if (stall) begin
        tick(idle, idle);
      end else if ((i % 2 == 1) && sent <= 18) begin
        tick(mk(32'h400 + 32'(4*sent)), mk(32'h404 + 32'(4*sent)));
        sent += 2;
      end else if (i % 4 == 0) begin
        tick(mk(32'h400 + 32'(4*sent)), idle);
        sent++;
      end else begin
        tick(idle, mk(32'h400 + 32'(4*sent)));
        sent++;
      end
    end
    repeat (10) tick(idle, idle);
    chk("wrap_count", tcount, base + 32'd20);

    // Reset mid-drain with 3 records buffered
    tick(mk(32'h300), mk(32'h304));
    tick(mk(32'h308), mk(32'h30C));
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", wb_valid, 0);
    chk("mid_rst_pc", wb_pc, 0);
    chk("mid_rst_wdata", wb_wdata, 0);
    chk("mid_rst_count", tcount, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_stall", stall, 0);
    expq.delete();
    mcount = 0;
    mtc = 0;
    movf = 1'b0;
    @(negedge clk) reset = 1'b0;
    repeat (3) tick(idle, idle);
    chk("post_rst_idle", wb_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
